perf_stat_monitor: RTL and testbench

- Synthesisable, parametrised successor to the bench-side instruction-count and halt-dump logic.
- Sits beside the pipeline's writeback/retire stage.
- Counts cycles, stall cycles, total retired instructions and N per-class retired instructions.
- Detects the HALT opcode, waits a programmable drain window, then streams every counter out over a valid/ready port and raises done.

---
 rtl/perf_stat_monitor.sv | 179 +++++++++++++++++
 tb/tb_perf_stat_monitor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_stat_monitor.sv
// perf_stat_monitor
//   Retire-stage performance monitor. Counts cycles, stall cycles, total
//   retired instructions and NUM_CLASSES per-class retired instructions.
//   When the HALT opcode retires it waits DRAIN_CYCLES cycles, then streams
//   every counter out over a valid/ready port and raises done.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   retire_valid   one instruction retires this cycle
//   retire_class   class index of the retiring instruction
//   retire_opcode  opcode of the retiring instruction
//   stall          pipeline stalled this cycle
//   clear          zero all counters (RUN only)
//   halt_seen      HALT has retired (sticky)
//   cycle_count    live cycle counter
//   dump_valid     dump word available
//   dump_ready     consumer accepts the dump word
//   dump_idx       index of the current dump word
//   dump_data      current dump word
//   done           dump complete
module perf_stat_monitor #(
    parameter int unsigned       NUM_CLASSES  = 4,
    parameter int unsigned       CNT_W        = 32,
    parameter int unsigned       OPC_W        = 6,
    parameter logic [OPC_W-1:0]  HALT_OPCODE  = 6'b010001,
    parameter int unsigned       DRAIN_CYCLES = 6,
    localparam int unsigned      CLS_W        = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int unsigned      DUMP_LEN     = NUM_CLASSES + 3,
    localparam int unsigned      IDX_W        = $clog2(DUMP_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid,
    input  logic [CLS_W-1:0] retire_class,
    input  logic [OPC_W-1:0] retire_opcode,
    input  logic             stall,
    input  logic             clear,
    output logic             halt_seen,
    output logic [CNT_W-1:0] cycle_count,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [IDX_W-1:0] dump_idx,
    output logic [CNT_W-1:0] dump_data,
    output logic             done
);

    localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t             state;
    logic [DRN_W-1:0]   drain_q;

    logic [CNT_W-1:0]   cyc_q, stl_q, tot_q;
    logic [CNT_W-1:0]   cls_q [NUM_CLASSES];
    logic [CNT_W-1:0]   cyc_d, stl_d, tot_d;
    logic [CNT_W-1:0]   cls_d [NUM_CLASSES];

    logic               counting;
    logic               do_clear;
    logic               halt_hit;
    logic [IDX_W-1:0]   nxt_idx;
    logic [CNT_W-1:0]   nxt_word;

    // Saturating increment: an all-ones counter stays put instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign cycle_count = cyc_q;

    // Next counter values. Counting runs in RUN and DRAIN; clear only in RUN,
    // where it beats any simultaneous increment.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        counting = (state == S_RUN) || (state == S_DRAIN);
        do_clear = (state == S_RUN) && clear;
        halt_hit = (state == S_RUN) && retire_valid && (retire_opcode == HALT_OPCODE);
        cyc_d    = cyc_q;
        stl_d    = stl_q;
        tot_d    = tot_q;
        cls_d    = cls_q;
        if (do_clear) begin
            cyc_d = '0;
            stl_d = '0;
            tot_d = '0;
            for (int k = 0; k < int'(NUM_CLASSES); k++) cls_d[k] = '0;
        end else if (counting) begin
            cyc_d = sat_inc(cyc_q, 1'b1);
            stl_d = sat_inc(stl_q, stall);
            tot_d = sat_inc(tot_q, retire_valid);
            // An out-of-range class matches no k, so it lands in tot only.
            for (int k = 0; k < int'(NUM_CLASSES); k++)
                cls_d[k] = sat_inc(cls_q[k], retire_valid && (retire_class == CLS_W'(k)));
        end
    end

    // Word that follows the current dump index; counters are frozen in DUMP,
    // so it can be taken straight from the registered counters.
    always_comb begin
        nxt_idx  = dump_idx + IDX_W'(1);
        nxt_word = '0;
        if (nxt_idx == IDX_W'(1)) nxt_word = stl_q;
        if (nxt_idx == IDX_W'(2)) nxt_word = tot_q;
        for (int k = 0; k < int'(NUM_CLASSES); k++)
            if (nxt_idx == IDX_W'(k + 3)) nxt_word = cls_q[k];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the class counters are a handful of flops, not a RAM, so they are reset like any register.
            state      <= S_RUN;
            drain_q    <= '0;
            cyc_q      <= '0;
            stl_q      <= '0;
            tot_q      <= '0;
            for (int k = 0; k < int'(NUM_CLASSES); k++) cls_q[k] <= '0;
            halt_seen  <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cyc_q <= cyc_d;
            stl_q <= stl_d;
            tot_q <= tot_d;
            cls_q <= cls_d;
            case (state)
                S_RUN: begin
                    if (halt_hit) begin
                        halt_seen <= 1'b1;
                        drain_q   <= DRN_W'(DRAIN_CYCLES);
                        if (DRAIN_CYCLES == 0) begin
                            // Word 0 is the cycle count as it settles on this edge.
                            state      <= S_DUMP;
                            dump_valid <= 1'b1;
                            dump_idx   <= '0;
                            dump_data  <= cyc_d;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q - DRN_W'(1);
                    if (drain_q == DRN_W'(1)) begin
                        state      <= S_DUMP;
                        dump_valid <= 1'b1;
                        dump_idx   <= '0;
                        dump_data  <= cyc_d;
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (dump_idx == IDX_W'(DUMP_LEN - 1)) begin
                            state      <= S_DONE;
                            dump_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            dump_idx  <= nxt_idx;
                            dump_data <= nxt_word;
                        end
                    end
                end
                S_DONE: begin
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_stat_monitor.sv
// tb_perf_stat_monitor
//   Three monitor instances share the stimulus inputs, each with its own
//   reset: A (defaults), B (CNT_W=4, saturation), C (NUM_CLASSES=5,
//   DRAIN_CYCLES=0, out-of-range classes). Expected counter values come from
//   a plain event-count model; the dump is checked against the list of words
//   the model predicts.
module tb_perf_stat_monitor;

    localparam logic [5:0] HALT = 6'b010001;

    logic       clk;
    logic       rst_a, rst_b, rst_c;
    logic       retire_valid, stall, clear, dump_ready;
    logic [2:0] retire_class;
    logic [5:0] retire_opcode;

    logic        a_halt, a_dv, a_done;
    logic [31:0] a_cyc, a_data;
    logic [2:0]  a_idx;
    logic        b_halt, b_dv, b_done;
    logic [3:0]  b_cyc, b_data;
    logic [2:0]  b_idx;
    logic        c_halt, c_dv, c_done;
    logic [31:0] c_cyc, c_data;
    logic [2:0]  c_idx;

    perf_stat_monitor dut_a (
        .clk(clk), .reset(rst_a), .retire_valid(retire_valid), .retire_class(retire_class[1:0]),
        .retire_opcode(retire_opcode), .stall(stall), .clear(clear), .halt_seen(a_halt),
        .cycle_count(a_cyc), .dump_valid(a_dv), .dump_ready(dump_ready), .dump_idx(a_idx),
        .dump_data(a_data), .done(a_done)
    );

    perf_stat_monitor #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_b), .retire_valid(retire_valid), .retire_class(retire_class[1:0]),
        .retire_opcode(retire_opcode), .stall(stall), .clear(clear), .halt_seen(b_halt),
        .cycle_count(b_cyc), .dump_valid(b_dv), .dump_ready(dump_ready), .dump_idx(b_idx),
        .dump_data(b_data), .done(b_done)
    );

    perf_stat_monitor #(.NUM_CLASSES(5), .DRAIN_CYCLES(0)) dut_c (
        .clk(clk), .reset(rst_c), .retire_valid(retire_valid), .retire_class(retire_class),
        .retire_opcode(retire_opcode), .stall(stall), .clear(clear), .halt_seen(c_halt),
        .cycle_count(c_cyc), .dump_valid(c_dv), .dump_ready(dump_ready), .dump_idx(c_idx),
        .dump_data(c_data), .done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation mux: sel picks the instance under test.
    int          sel;
    logic        o_halt, o_valid, o_done;
    logic [31:0] o_cyc, o_data, o_idx;

    always_comb begin
        case (sel)
            1: begin
                o_halt = b_halt; o_valid = b_dv; o_done = b_done;
                o_cyc = {28'd0, b_cyc}; o_data = {28'd0, b_data}; o_idx = {29'd0, b_idx};
            end
            2: begin
                o_halt = c_halt; o_valid = c_dv; o_done = c_done;
                o_cyc = c_cyc; o_data = c_data; o_idx = {29'd0, c_idx};
            end
            default: begin
                o_halt = a_halt; o_valid = a_dv; o_done = a_done;
                o_cyc = a_cyc; o_data = a_data; o_idx = {29'd0, a_idx};
            end
        endcase
    end

    // Reference model: counts of events, saturating at m_max.
    logic [31:0] m_cyc, m_stl, m_tot, m_max;
    logic [31:0] m_cls [8];
    int          m_ncls;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v < m_max) ? v + 32'd1 : v;
    endfunction

    task automatic model_reset(input logic [31:0] maxv, input int ncls);
        m_cyc = 0; m_stl = 0; m_tot = 0;
        for (int k = 0; k < 8; k++) m_cls[k] = 0;
        m_max  = maxv;
        m_ncls = ncls;
    endtask

    function automatic logic [5:0] rand_opc();
        logic [5:0] o;
        o = 6'($urandom_range(0, 63));
        if (o == HALT) o = o + 6'd1;
        return o;
    endfunction

    // One counting cycle (RUN or DRAIN). run=1 means the monitor is in RUN,
    // where clear is honoured.
    task automatic cyc_step(input bit rv, input int cls, input bit halt_op,
                            input bit stl, input bit clr, input bit run);
        retire_valid  = rv;
        retire_class  = 3'(cls);
        retire_opcode = halt_op ? HALT : rand_opc();
        stall         = stl;
        clear         = clr;
        dump_ready    = 1'($urandom);
        if (run && clr) begin
            m_cyc = 0; m_stl = 0; m_tot = 0;
            for (int k = 0; k < 8; k++) m_cls[k] = 0;
        end else begin
            m_cyc = sat1(m_cyc);
            if (stl) m_stl = sat1(m_stl);
            if (rv) begin
                m_tot = sat1(m_tot);
                if (cls < m_ncls) m_cls[cls] = sat1(m_cls[cls]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_halt_seen"},  {31'd0, o_halt},  32'd0);
        check({pfx, "_cycle_count"}, o_cyc,            32'd0);
        check({pfx, "_dump_valid"}, {31'd0, o_valid}, 32'd0);
        check({pfx, "_dump_idx"},   o_idx,            32'd0);
        check({pfx, "_dump_data"},  o_data,           32'd0);
        check({pfx, "_done"},       {31'd0, o_done},  32'd0);
    endtask

    // Drain window: dump_valid stays low for n cycles, counting continues.
    task automatic drain(input int n, input bit noisy);
        for (int s = 0; s < n; s++) begin
            check("drain_valid_low", {31'd0, o_valid}, 32'd0);
            check("drain_halt_seen", {31'd0, o_halt}, 32'd1);
            if (noisy) cyc_step(s == 3, 0, s == 3, 1'b0, s < 3, 1'b0);
            else       cyc_step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Collect the dump. mode 0: ready always 1; mode 1: ready low for five
    // cycles, then alternating 1/0. Inputs other than dump_ready are random
    // noise that must not disturb the frozen counters. abort_at >= 0 stops
    // while that index is presented.
    task automatic do_dump(input int mode, input int abort_at);
        logic [31:0] exp [8];
        int          len;
        int          acc;
        bit          rdy;
        bit          aborted;
        len = m_ncls + 3;
        acc = 0;
        aborted = 1'b0;
        exp[0] = m_cyc; exp[1] = m_stl; exp[2] = m_tot;
        for (int k = 0; k < 5; k++) exp[3 + k] = m_cls[k];
        for (int t = 0; t < 200 && acc < len && !aborted; t++) begin
            rdy = (mode == 0) ? 1'b1 : ((t < 5) ? 1'b0 : ((t - 5) % 2 == 0));
            dump_ready    = rdy;
            retire_valid  = 1'($urandom);
            stall         = 1'($urandom);
            clear         = 1'($urandom);
            retire_class  = 3'($urandom);
            retire_opcode = 6'($urandom);
            check("dump_valid", {31'd0, o_valid}, 32'd1);
            check("dump_idx", o_idx, 32'(acc));
            check("dump_data", o_data, exp[acc]);
            check("done_early", {31'd0, o_done}, 32'd0);
            if (acc == abort_at) begin
                aborted = 1'b1;
            end else begin
                if (rdy) acc++;
                @(posedge clk);
                #1;
            end
        end
        if (!aborted) begin
            check("dump_words", 32'(acc), 32'(len));
            check("done_after_dump", {31'd0, o_done}, 32'd1);
            check("valid_after_dump", {31'd0, o_valid}, 32'd0);
            check("cyc_frozen", o_cyc, m_cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        retire_valid = 1'b0; retire_class = '0; retire_opcode = '0;
        stall = 1'b0; clear = 1'b0; dump_ready = 1'b0;
        model_reset(32'hFFFF_FFFF, 4);
        repeat (2) @(posedge clk);
        #1;

        // ---------------- Instance A ----------------
        check_zero("reset_a");
        rst_a = 1'b1;
        for (int i = 0; i < 20; i++) cyc_step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_cycle_count", o_cyc, m_cyc);
        check("idle_dump_valid", {31'd0, o_valid}, 32'd0);
        check("idle_done", {31'd0, o_done}, 32'd0);

        // Random traffic, no HALT, no clear.
        for (int i = 0; i < 40; i++) begin
            cyc_step(1'($urandom), $urandom_range(0, 3), 1'b0, 1'($urandom), 1'b0, 1'b1);
            if (i % 10 == 9) check("rand_cycle_count", o_cyc, m_cyc);
        end

        // Five retires, then clear together with a retire and a stall.
        for (int i = 0; i < 5; i++) cyc_step(1'b1, i % 4, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_cycle_count", o_cyc, m_cyc);
        check("clear_halt_seen", {31'd0, o_halt}, 32'd0);

        // Directed run: classes 0,0,1,2,3,3,3, two stalls, HALT in class 3.
        cyc_step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc_step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc_step(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        // Drain with clear (ignored) and a second HALT (counted, no effect).
        drain(6, 1'b1);
        do_dump(1, -1);
        for (int i = 0; i < 3; i++) begin
            cyc_step(1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
            m_cyc = m_cyc; // nothing counts in DONE; model is restored below
        end
        check("done_hold", {31'd0, o_done}, 32'd1);
        check("done_halt_seen", {31'd0, o_halt}, 32'd1);
        check("done_valid_low", {31'd0, o_valid}, 32'd0);

        // ---------------- Instance B: 4-bit saturation ----------------
        sel = 1;
        model_reset(32'd15, 4);
        rst_b = 1'b1;
        for (int i = 0; i < 20; i++) cyc_step(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_cycle_count", o_cyc, m_cyc);
        cyc_step(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        drain(6, 1'b0);
        do_dump(0, -1);

        // ---------------- Instance C: no drain, 5 classes ----------------
        sel = 2;
        model_reset(32'hFFFF_FFFF, 5);
        rst_c = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc_step(1'($urandom), $urandom_range(0, 4), 1'b0, 1'($urandom), 1'b0, 1'b1);
        cyc_step(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        check("d0_halt_seen", {31'd0, o_halt}, 32'd1);
        do_dump(0, 3);
        rst_c = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset_mid_dump");
        rst_c = 1'b1;
        model_reset(32'hFFFF_FFFF, 5);
        cyc_step(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++)
            cyc_step(1'($urandom), $urandom_range(0, 7), 1'b0, 1'($urandom), 1'b0, 1'b1);
        check("c_cycle_count", o_cyc, m_cyc);
        cyc_step(1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1);
        do_dump(0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
